// File: rtl/game_pkg.sv
// Shared definitions for the frog game sequencer: FSM state encoding and defaults.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAY     = 3'd1,
    S_DEATH    = 3'd2,
    S_LEVEL_UP = 3'd3,
    S_OVER     = 3'd4
  } state_e;

  localparam int unsigned START_LIVES_DEFAULT = 3;

  // Counter width for a count of n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// Event, button and status signals between the game sequencer and the rest of the game.
interface game_flow_controller_if;

  logic [3:0] i_Buttons;
  logic       i_Frog_At_Top;
  logic       i_Collision;
  logic [2:0] o_State;
  logic       o_Freeze;
  logic       o_Reset_Frog;
  logic       o_Reset_Lives;
  logic [3:0] o_Level;
  logic [1:0] o_Lives;
  logic       o_Game_Over;

  modport master (
    output i_Buttons, i_Frog_At_Top, i_Collision,
    input  o_State, o_Freeze, o_Reset_Frog, o_Reset_Lives, o_Level, o_Lives, o_Game_Over
  );

  modport slave (
    input  i_Buttons, i_Frog_At_Top, i_Collision,
    output o_State, o_Freeze, o_Reset_Frog, o_Reset_Lives, o_Level, o_Lives, o_Game_Over
  );

endinterface

// File: rtl/button_hold_detector.sv
// Start-press edge detector and all-buttons hold counter for forced restart.
module button_hold_detector
  import game_pkg::*;
#(
  parameter int unsigned HOLD = 50_000_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_Buttons,
  output logic       o_Start_Press,
  output logic       o_Restart
);

  localparam int unsigned HW = cnt_width(HOLD);

  logic [3:0]    btn_hist_q, btn_hist_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          fired_q, fired_d;
  logic          all_ones;
  logic          at_limit;

  assign all_ones = (i_Buttons == 4'b1111);
  assign at_limit = (hold_q == HW'(HOLD - 1));

  // Once the counter saturates, fired_q blocks further restarts until release.
  always_comb begin
    btn_hist_d    = i_Buttons;
    o_Start_Press = |(i_Buttons & ~btn_hist_q);
    o_Restart     = all_ones && at_limit && !fired_q;
    hold_d        = '0;
    if (all_ones) begin
      hold_d = at_limit ? hold_q : hold_q + HW'(1);
    end
    fired_d = all_ones && (fired_q || o_Restart);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      btn_hist_q <= '1;
      hold_q     <= '0;
      fired_q    <= 1'b0;
    end else begin
      btn_hist_q <= btn_hist_d;
      hold_q     <= hold_d;
      fired_q    <= fired_d;
    end
  end

endmodule

// File: rtl/game_flow_controller.sv
// Frog game sequencer: play/pause FSM, freeze timer, level and lives registers.
module game_flow_controller
  import game_pkg::*;
#(
  parameter int unsigned MAX_LEVEL    = 9,
  parameter int unsigned START_LIVES  = START_LIVES_DEFAULT,
  parameter int unsigned DEATH_HOLD   = 25_000_000,
  parameter int unsigned WIN_HOLD     = 12_500_000,
  parameter int unsigned RESTART_HOLD = 50_000_000
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  game_flow_controller_if.slave bus
);

  localparam int unsigned TW = cnt_width((DEATH_HOLD > WIN_HOLD) ? DEATH_HOLD : WIN_HOLD);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    level_q, level_d;
  logic [1:0]    lives_q, lives_d;
  logic          reset_frog_q, reset_frog_d;
  logic          reset_lives_q, reset_lives_d;
  logic          start_press;
  logic          restart;

  button_hold_detector #(
    .HOLD(RESTART_HOLD)
  ) u_buttons (
    .i_Clk         (i_Clk),
    .i_Rst         (i_Rst),
    .i_Buttons     (bus.i_Buttons),
    .o_Start_Press (start_press),
    .o_Restart     (restart)
  );

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    level_d       = level_q;
    lives_d       = lives_q;
    reset_frog_d  = 1'b0;
    reset_lives_d = 1'b0;
    if (restart) begin
      state_d       = S_IDLE;
      level_d       = 4'd1;
      lives_d       = 2'(START_LIVES);
      reset_frog_d  = 1'b1;
      reset_lives_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_press) begin
            state_d      = S_PLAY;
            reset_frog_d = 1'b1;
          end
        end
        S_PLAY: begin
          if (bus.i_Collision) begin
            state_d = S_DEATH;
            lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
            timer_d = TW'(DEATH_HOLD - 1);
          end else if (bus.i_Frog_At_Top) begin
            state_d = S_LEVEL_UP;
            timer_d = TW'(WIN_HOLD - 1);
          end
        end
        S_DEATH: begin
          if (timer_q == '0) begin
            if (lives_q == 2'd0) begin
              state_d = S_OVER;
            end else begin
              state_d      = S_PLAY;
              reset_frog_d = 1'b1;
            end
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        S_LEVEL_UP: begin
          if (timer_q == '0) begin
            state_d      = S_PLAY;
            reset_frog_d = 1'b1;
            level_d      = (level_q >= 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : level_q + 4'd1;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        S_OVER: begin
          if (start_press) begin
            state_d       = S_IDLE;
            level_d       = 4'd1;
            lives_d       = 2'(START_LIVES);
            reset_frog_d  = 1'b1;
            reset_lives_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      level_q       <= 4'd1;
      lives_q       <= 2'(START_LIVES);
      reset_frog_q  <= 1'b0;
      reset_lives_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      level_q       <= level_d;
      lives_q       <= lives_d;
      reset_frog_q  <= reset_frog_d;
      reset_lives_q <= reset_lives_d;
    end
  end

  assign bus.o_State       = state_q;
  assign bus.o_Freeze      = (state_q != S_PLAY);
  assign bus.o_Reset_Frog  = reset_frog_q;
  assign bus.o_Reset_Lives = reset_lives_q;
  assign bus.o_Level       = level_q;
  assign bus.o_Lives       = lives_q;
  assign bus.o_Game_Over   = (state_q == S_OVER);

endmodule

// File: tb/tb_game_flow_controller.sv
// Table-driven, scoreboarded bench for game_flow_controller with short hold times.
module tb_game_flow_controller;

  localparam int ST_IDLE = 0;
  localparam int ST_PLAY = 1;
  localparam int ST_DEATH = 2;
  localparam int ST_LU = 3;
  localparam int ST_OVER = 4;

  typedef struct {
    string      name;
    logic [3:0] b;
    logic       t;
    logic       c;
    logic [12:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  vec_t        vecs[$];
  logic [12:0] sb_q[$];
  string       sbn_q[$];

  game_flow_controller_if bus();

  game_flow_controller #(
    .MAX_LEVEL    (3),
    .START_LIVES  (3),
    .DEATH_HOLD   (4),
    .WIN_HOLD     (3),
    .RESTART_HOLD (5)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Packed view: {state, freeze, reset_frog, reset_lives, level, lives, game_over}
  function automatic logic [12:0] ex(int st, bit rf, bit rl, int lvl, int lv);
    logic fr;
    logic go;
    fr = (st != ST_PLAY);
    go = (st == ST_OVER);
    return {3'(st), fr, rf, rl, 4'(lvl), 2'(lv), go};
  endfunction

  function automatic logic [12:0] actual();
    return {bus.o_State, bus.o_Freeze, bus.o_Reset_Frog, bus.o_Reset_Lives,
            bus.o_Level, bus.o_Lives, bus.o_Game_Over};
  endfunction

  function automatic void add(string n, logic [3:0] b, logic t, logic c, logic [12:0] e);
    vec_t v;
    v.name = n; v.b = b; v.t = t; v.c = c; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic check(string n, logic [12:0] got, logic [12:0] expv);
    checks++;
    if (got !== expv)
      $display("FAIL %s: got %h expected %h", n, got, expv);
    else
      passes++;
  endtask

  task automatic apply(vec_t v);
    logic [12:0] e;
    string       n;
    @(negedge clk);
    bus.i_Buttons     = v.b;
    bus.i_Frog_At_Top = v.t;
    bus.i_Collision   = v.c;
    sb_q.push_back(v.exp);
    sbn_q.push_back(v.name);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n = sbn_q.pop_front();
    check(n, actual(), e);
  endtask

  initial begin
    int lvl;
    vec_t hv;

    bus.i_Buttons     = 4'b0000;
    bus.i_Frog_At_Top = 1'b0;
    bus.i_Collision   = 1'b0;

    // Start, then simultaneous events with collision winning.
    add("idle", 0, 0, 0, ex(ST_IDLE, 0, 0, 1, 3));
    add("start", 1, 0, 0, ex(ST_PLAY, 1, 0, 1, 3));
    add("play_hold", 1, 0, 0, ex(ST_PLAY, 0, 0, 1, 3));
    add("play", 0, 0, 0, ex(ST_PLAY, 0, 0, 1, 3));
    add("both_evt", 0, 1, 1, ex(ST_DEATH, 0, 0, 1, 2));
    for (int i = 0; i < 3; i++) add("death_wait", 0, 0, 0, ex(ST_DEATH, 0, 0, 1, 2));
    add("death_exit", 0, 0, 0, ex(ST_PLAY, 1, 0, 1, 2));

    // Three wins: level 2, 3, then saturated at 3.
    lvl = 1;
    for (int k = 0; k < 3; k++) begin
      add("win", 0, 1, 0, ex(ST_LU, 0, 0, lvl, 2));
      for (int i = 0; i < 2; i++) add("win_wait", 0, 0, 0, ex(ST_LU, 0, 0, lvl, 2));
      lvl = (lvl < 3) ? lvl + 1 : 3;
      add("win_exit", 0, 0, 0, ex(ST_PLAY, 1, 0, lvl, 2));
    end

    // Collision during LEVEL_UP must not alter lives or the hold length.
    add("lu_enter", 0, 1, 0, ex(ST_LU, 0, 0, 3, 2));
    add("lu_coll", 0, 0, 1, ex(ST_LU, 0, 0, 3, 2));
    add("lu_wait", 0, 0, 0, ex(ST_LU, 0, 0, 3, 2));
    add("lu_exit", 0, 0, 0, ex(ST_PLAY, 1, 0, 3, 2));

    // Two more collisions down to game over.
    add("coll2", 0, 0, 1, ex(ST_DEATH, 0, 0, 3, 1));
    for (int i = 0; i < 3; i++) add("death2_wait", 0, 0, 0, ex(ST_DEATH, 0, 0, 3, 1));
    add("death2_exit", 0, 0, 0, ex(ST_PLAY, 1, 0, 3, 1));
    add("coll3", 0, 0, 1, ex(ST_DEATH, 0, 0, 3, 0));
    for (int i = 0; i < 3; i++) add("death3_wait", 0, 0, 0, ex(ST_DEATH, 0, 0, 3, 0));
    add("over", 0, 0, 0, ex(ST_OVER, 0, 0, 3, 0));
    add("over_stay", 0, 0, 0, ex(ST_OVER, 0, 0, 3, 0));
    add("over_press", 2, 0, 0, ex(ST_IDLE, 1, 1, 1, 3));
    add("idle_rel", 0, 0, 0, ex(ST_IDLE, 0, 0, 1, 3));

    // Events are ignored in IDLE.
    add("idle_coll", 0, 0, 1, ex(ST_IDLE, 0, 0, 1, 3));
    add("idle_top", 0, 1, 0, ex(ST_IDLE, 0, 0, 1, 3));

    // Forced restart from DEATH, then no second restart while still held.
    add("start2", 4, 0, 0, ex(ST_PLAY, 1, 0, 1, 3));
    add("play2", 0, 0, 0, ex(ST_PLAY, 0, 0, 1, 3));
    add("hold_coll", 15, 0, 1, ex(ST_DEATH, 0, 0, 1, 2));
    for (int i = 0; i < 3; i++) add("hold_death", 15, 0, 0, ex(ST_DEATH, 0, 0, 1, 2));
    add("restart", 15, 0, 0, ex(ST_IDLE, 1, 1, 1, 3));
    for (int i = 0; i < 10; i++) add("hold_sat", 15, 0, 0, ex(ST_IDLE, 0, 0, 1, 3));
    add("release", 0, 0, 0, ex(ST_IDLE, 0, 0, 1, 3));
    add("start3", 1, 0, 0, ex(ST_PLAY, 1, 0, 1, 3));
    add("play3", 0, 0, 0, ex(ST_PLAY, 0, 0, 1, 3));
    add("lu_pre_rst", 0, 1, 0, ex(ST_LU, 0, 0, 1, 3));

    #12;
    check("reset_state", actual(), ex(ST_IDLE, 0, 0, 1, 3));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset mid LEVEL_UP, with a button held through reset.
    @(negedge clk);
    bus.i_Buttons = 4'b0001;
    #2 rst = 1'b1;
    #1 check("async_rst", actual(), ex(ST_IDLE, 0, 0, 1, 3));
    @(negedge clk);
    rst = 1'b0;
    hv.name = "held_thru_rst"; hv.b = 4'b0001; hv.t = 0; hv.c = 0; hv.exp = ex(ST_IDLE, 0, 0, 1, 3);
    apply(hv);
    hv.name = "rst_release"; hv.b = 4'b0000; hv.exp = ex(ST_IDLE, 0, 0, 1, 3);
    apply(hv);
    hv.name = "rst_start"; hv.b = 4'b0001; hv.exp = ex(ST_PLAY, 1, 0, 1, 3);
    apply(hv);
    hv.name = "rst_top"; hv.b = 4'b0000; hv.t = 1; hv.exp = ex(ST_LU, 0, 0, 1, 3);
    apply(hv);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
